microwave_timer: RTL and testbench

- Countdown timer that supplies `timer_done` to the microwave `control` block and consumes its `mag` output. It is the other end of the `mag`/`timer_done` interface.
- Keypad digits shift into a 4-digit BCD MM:SS register.
- The block counts down one second per prescaler period while `mag`=1.
- `timer_done` is high whenever the stored time is 00:00.

---
 rtl/microwave_pkg.sv | 67 ++++++
 rtl/microwave_tick_gen.sv | 47 ++++
 rtl/microwave_timer.sv | 87 ++++++++
 tb/tb_microwave_timer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types, constants and BCD time helpers for the microwave countdown timer.
// Optional feature macro: MICROWAVE_TIMER_ADD30_EN (adds the +30 s helper).
package microwave_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    localparam mmss_t MMSS_ZERO = '{min_tens: 4'd0, min_ones: 4'd0, sec_tens: 4'd0, sec_ones: 4'd0};
    localparam mmss_t MMSS_MAX  = '{min_tens: 4'd9, min_ones: 4'd9, sec_tens: 4'd9, sec_ones: 4'd9};

    // One-second decrement with borrow; seconds tens may legally exceed 5
    // after keypad entry, so only the borrow paths reload 59.
    function automatic mmss_t mmss_dec(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.sec_ones != 4'd0) begin
            r.sec_ones = t.sec_ones - 4'd1;
        end else if (t.sec_tens != 4'd0) begin
            r.sec_tens = t.sec_tens - 4'd1;
            r.sec_ones = 4'd9;
        end else if (t.min_ones != 4'd0) begin
            r.min_ones = t.min_ones - 4'd1;
            r.sec_tens = 4'd5;
            r.sec_ones = 4'd9;
        end else if (t.min_tens != 4'd0) begin
            r.min_tens = t.min_tens - 4'd1;
            r.min_ones = 4'd9;
            r.sec_tens = 4'd5;
            r.sec_ones = 4'd9;
        end
        return r;
    endfunction

`ifdef MICROWAVE_TIMER_ADD30_EN
    // Add thirty seconds; seconds >= 30 carry into minutes, and a minute
    // overflow past 99 saturates the whole display to 99:99.
    function automatic mmss_t mmss_add30(input mmss_t t);
        mmss_t      r;
        logic [6:0] secs;
        logic [6:0] mins;
        secs = 7'(t.sec_tens) * 7'd10 + 7'(t.sec_ones);
        mins = 7'(t.min_tens) * 7'd10 + 7'(t.min_ones);
        if (secs < 7'd30) begin
            secs = secs + 7'd30;
        end else begin
            secs = secs - 7'd30;
            mins = mins + 7'd1;
        end
        if (mins > 7'd99) begin
            r = MMSS_MAX;
        end else begin
            r.min_tens = 4'(mins / 7'd10);
            r.min_ones = 4'(mins % 7'd10);
            r.sec_tens = 4'(secs / 7'd10);
            r.sec_ones = 4'(secs % 7'd10);
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/microwave_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick
// on the last count. Holds while disabled so a paused run keeps its partial second.
module microwave_tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_MAX);

    // Next count: clear wins, hold only freezes the terminal count so the
    // pending tick is retaken on the following cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                if (!hold) begin
                    cnt_d = '0;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/microwave_timer.sv
// Microwave countdown timer: keypad digits shift into an MM:SS BCD register,
// which counts down once per second while mag is high. timer_done flags 00:00.
// Optional feature macro: MICROWAVE_TIMER_ADD30_EN adds the add30 strobe input.
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       clearn,
    input  logic       mag,
`ifdef MICROWAVE_TIMER_ADD30_EN
    input  logic       add30,
`endif
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done
);

    mmss_t time_q;
    mmss_t time_d;
    logic  tick;
    logic  entry_ok;
    logic  entry_take;
    logic  add_req;

`ifdef MICROWAVE_TIMER_ADD30_EN
    assign add_req = add30;
`else
    assign add_req = 1'b0;
`endif

    assign timer_done = (time_q == MMSS_ZERO);
    assign entry_ok   = !mag && digit_valid && (digit <= 4'd9);
    // Entry only lands when nothing of higher priority claims the cycle.
    assign entry_take = entry_ok && clearn && !add_req && !tick;

    microwave_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (mag && !timer_done),
        .clr   (!clearn || entry_take || timer_done),
        .hold  (add_req),
        .tick  (tick)
    );

    // Next time value in priority order: clear, add30, tick, keypad entry.
    always_comb begin
        time_d = time_q;
        if (!clearn) begin
            time_d = MMSS_ZERO;
`ifdef MICROWAVE_TIMER_ADD30_EN
        end else if (add_req) begin
            time_d = mmss_add30(time_q);
`endif
        end else if (tick) begin
            time_d = mmss_dec(time_q);
        end else if (entry_ok) begin
            time_d.min_tens = time_q.min_ones;
            time_d.min_ones = time_q.sec_tens;
            time_d.sec_tens = time_q.sec_ones;
            time_d.sec_ones = digit;
        end
    end

    // Time register; reset zeroes it regardless of mag.
    always_ff @(posedge clk) begin
        if (reset) begin
            time_q <= MMSS_ZERO;
        end else begin
            time_q <= time_d;
        end
    end

    assign min_tens = time_q.min_tens;
    assign min_ones = time_q.min_ones;
    assign sec_tens = time_q.sec_tens;
    assign sec_ones = time_q.sec_ones;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed testbench for microwave_timer with TICK_DIV=4.
// Optional feature macro: MICROWAVE_TIMER_ADD30_EN enables the add30 vectors.
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       clearn = 1'b1;
    logic       mag = 1'b0;
`ifdef MICROWAVE_TIMER_ADD30_EN
    logic       add30 = 1'b0;
`endif
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    microwave_timer #(
        .TICK_DIV (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .clearn      (clearn),
        .mag         (mag),
`ifdef MICROWAVE_TIMER_ADD30_EN
        .add30       (add30),
`endif
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .timer_done  (timer_done)
    );

    function automatic logic [15:0] now();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit = d;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic load(input logic [15:0] t);
        clearn = 1'b0;
        step();
        clearn = 1'b1;
        key(t[15:12]);
        key(t[11:8]);
        key(t[7:4]);
        key(t[3:0]);
    endtask

    // Load a time, run exactly one prescaler period, stop.
    task automatic run_one(input logic [15:0] t, input logic [15:0] exp, input string tag);
        load(t);
        mag = 1'b1;
        step(4);
        mag = 1'b0;
        check(tag, 32'(now()), 32'(exp));
    endtask

    initial begin
        // Reset state
        step(2);
        reset = 1'b0;
        check("reset_time", 32'(now()), 32'h0000);
        check("reset_done", 32'(timer_done), 32'd1);

        // Keypad entry 1,3,(12 ignored),0
        key(4'd1);
        key(4'd3);
        check("entry_13", 32'(now()), 32'h0013);
        key(4'd12);
        check("entry_bad_digit", 32'(now()), 32'h0013);
        key(4'd0);
        check("entry_0130", 32'(now()), 32'h0130);
        check("entry_done_low", 32'(timer_done), 32'd0);

        // 00:02 runs down to 00:00 and stops
        load(16'h0002);
        mag = 1'b1;
        step(3);
        check("run_c3", 32'(now()), 32'h0002);
        step(1);
        check("run_c4", 32'(now()), 32'h0001);
        step(3);
        check("run_c7", 32'(now()), 32'h0001);
        step(1);
        check("run_c8", 32'(now()), 32'h0000);
        check("run_c8_done", 32'(timer_done), 32'd1);
        step(6);
        check("run_hold_zero", 32'(now()), 32'h0000);
        mag = 1'b0;

        // Borrow cases
        run_one(16'h0100, 16'h0059, "dec_0100");
        run_one(16'h1000, 16'h0959, "dec_1000");
        run_one(16'h0090, 16'h0089, "dec_0090");

        // Pause/resume keeps the partial second; entry blocked while running
        load(16'h0005);
        mag = 1'b1;
        step(2);
        mag = 1'b0;
        step(10);
        check("pause_hold", 32'(now()), 32'h0005);
        mag = 1'b1;
        step(1);
        check("resume_r1", 32'(now()), 32'h0005);
        step(1);
        check("resume_r2", 32'(now()), 32'h0004);
        key(4'd7);
        check("entry_blocked", 32'(now()), 32'h0004);
        mag = 1'b0;

        // Clear coincident with tick
        load(16'h0003);
        mag = 1'b1;
        step(3);
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        check("clear_vs_tick", 32'(now()), 32'h0000);
        check("clear_done", 32'(timer_done), 32'd1);
        mag = 1'b0;

        // Reset mid-run
        load(16'h0123);
        mag = 1'b1;
        step(2);
        reset = 1'b1;
        step(1);
        check("reset_midrun", 32'(now()), 32'h0000);
        reset = 1'b0;
        mag = 1'b0;

`ifdef MICROWAVE_TIMER_ADD30_EN
        load(16'h0045);
        add30 = 1'b1; step(1); add30 = 1'b0;
        check("add30_0045", 32'(now()), 32'h0115);
        load(16'h0010);
        add30 = 1'b1; step(1); add30 = 1'b0;
        check("add30_0010", 32'(now()), 32'h0040);
        load(16'h9950);
        add30 = 1'b1; step(1); add30 = 1'b0;
        check("add30_sat", 32'(now()), 32'h9999);
        // add30 on the tick cycle: add applies, tick follows next cycle
        load(16'h0005);
        mag = 1'b1;
        step(3);
        add30 = 1'b1; step(1); add30 = 1'b0;
        check("add30_vs_tick", 32'(now()), 32'h0035);
        step(1);
        check("add30_tick_after", 32'(now()), 32'h0034);
        mag = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog bound on the whole run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
